// File: rtl/uart_tx_drain_if.sv
// FIFO-to-transmitter pop interface for the UART drain.
// Handshake: fifo_not_empty is the valid, fifo_dout is the show-ahead head word,
// and fifo_rd is a one-cycle pop strobe that only ever rises while fifo_not_empty=1.
interface uart_tx_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_not_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd;

    modport master (
        output fifo_not_empty,
        output fifo_dout,
        input  fifo_rd
    );

    modport slave (
        input  fifo_not_empty,
        input  fifo_dout,
        output fifo_rd
    );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pops words from a show-ahead FIFO and serialises them
// as start, LSB-first data, optional even parity and one or two stop bits.
module uart_tx_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 868,
    parameter int DIV_WIDTH  = 16,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    uart_tx_drain_if.slave      fifo,
    output logic                tx,
    output logic                busy,
    output logic [2:0]          fsm_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DIV_WIDTH-1:0] TICK_AT   = DIV_WIDTH'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic                 LAST_STOP = 1'(STOP_BITS - 1);

    state_t                state;
    state_t                state_next;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  par_bit;
    logic                  par_next;
    logic                  stop_cnt;
    logic                  tick;
    logic                  last_stop;
    logic                  pop;
    logic                  tx_next;

    assign tick      = (baud_cnt == TICK_AT);
    assign last_stop = (state == STOP) && tick && (stop_cnt == LAST_STOP);
    // Popping on the final stop tick lets the next start bit follow with no idle gap.
    assign pop       = !rst && enable && fifo.fifo_not_empty && ((state == IDLE) || last_stop);

    assign fifo.fifo_rd = pop;
    assign busy         = (state != IDLE);
    assign fsm_state    = state;

    always_comb begin
        state_next = state;
        shift_next = shift;
        par_next   = par_bit;
        tx_next    = 1'b1;
        if (pop) begin
            shift_next = fifo.fifo_dout;
            par_next   = ^fifo.fifo_dout;
        end
        case (state)
            IDLE:   if (pop) state_next = START;
            START:  if (tick) state_next = DATA;
            DATA: begin
                if (tick) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: if (tick) state_next = STOP;
            STOP:   if (last_stop) state_next = pop ? START : IDLE;
            default: state_next = IDLE;
        endcase
        // tx is registered, so it is computed from the state being entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state   <= state_next;
            shift   <= shift_next;
            par_bit <= par_next;
            tx      <= tx_next;
            if ((state == IDLE) || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + DIV_WIDTH'(1);
            end
            if (state == START) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && tick) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if ((state == STOP) && tick) begin
                stop_cnt <= last_stop ? 1'b0 : ~stop_cnt;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain: two instances (8N1 and 8E2, CLK_DIV=4)
// fed by small array FIFOs, with a UART receiver model for the random run.
module tb_uart_tx_drain;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable0 = 1'b0;
    logic enable1 = 1'b0;
    logic tx0, busy0, tx1, busy1;
    logic [2:0] st0, st1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem0 [0:255];
    logic [7:0] mem1 [0:255];
    int head0 = 0, tail0 = 0, head1 = 0, tail1 = 0;
    int bad_rd0 = 0, bad_rd1 = 0;

    logic tx_rec   [0:255];
    logic busy_rec [0:255];
    logic rd_rec   [0:255];
    logic tx_exp   [0:255];

    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];
    bit         rx_on = 1'b0;
    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    int         rx_k = 0;
    int         rx_frame_err = 0;
    logic [7:0] rx_byte = 8'h00;

    always #5 clk = ~clk;

    uart_tx_drain_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_drain_if #(.DATA_WIDTH(8)) bus1 ();

    assign bus0.fifo_not_empty = (head0 != tail0);
    assign bus0.fifo_dout      = mem0[head0[7:0]];
    assign bus1.fifo_not_empty = (head1 != tail1);
    assign bus1.fifo_dout      = mem1[head1[7:0]];

    uart_tx_drain #(.DATA_WIDTH(8), .CLK_DIV(DIV), .DIV_WIDTH(16), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable0), .fifo(bus0.slave),
        .tx(tx0), .busy(busy0), .fsm_state(st0)
    );

    uart_tx_drain #(.DATA_WIDTH(8), .CLK_DIV(DIV), .DIV_WIDTH(16), .PARITY_EN(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .enable(enable1), .fifo(bus1.slave),
        .tx(tx1), .busy(busy1), .fsm_state(st1)
    );

    // FIFO models: pop on the edge where fifo_rd is high.
    always @(posedge clk) begin
        if (bus0.fifo_rd) begin
            if ((head0 == tail0) || rst) bad_rd0++;
            head0 <= head0 + 1;
        end
        if (bus1.fifo_rd) begin
            if ((head1 == tail1) || rst) bad_rd1++;
            head1 <= head1 + 1;
        end
    end

    // Receiver model on tx0, sampling each bit at its centre.
    always @(posedge clk) begin
        if (!rx_on) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx0 === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % DIV) == DIV / 2) begin
                rx_k = rx_cnt / DIV;
                if (rx_k == 0) begin
                    if (tx0 !== 1'b0) begin
                        rx_frame_err++;
                        rx_active = 1'b0;
                    end
                end else if (rx_k <= 8) begin
                    rx_byte[rx_k-1] = tx0;
                end else begin
                    if (tx0 !== 1'b1) rx_frame_err++;
                    rx_q.push_back(rx_byte);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic push0(input logic [7:0] b);
        mem0[tail0[7:0]] = b;
        tail0 = tail0 + 1;
    endtask

    task automatic push1(input logic [7:0] b);
        mem1[tail1[7:0]] = b;
        tail1 = tail1 + 1;
    endtask

    task automatic record(input int sel, input int off, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sel == 0) begin
                tx_rec[off+i] = tx0;  busy_rec[off+i] = busy0;  rd_rec[off+i] = bus0.fifo_rd;
            end else begin
                tx_rec[off+i] = tx1;  busy_rec[off+i] = busy1;  rd_rec[off+i] = bus1.fifo_rd;
            end
        end
    endtask

    task automatic build_exp(input int off, input logic [7:0] b, input bit par_en,
                             input int stops, output int end_off);
        int k;
        k = off;
        for (int c = 0; c < DIV; c++) begin tx_exp[k] = 1'b0; k++; end
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < DIV; c++) begin tx_exp[k] = b[i]; k++; end
        if (par_en)
            for (int c = 0; c < DIV; c++) begin tx_exp[k] = ^b; k++; end
        for (int c = 0; c < stops * DIV; c++) begin tx_exp[k] = 1'b1; k++; end
        end_off = k;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push0(8'hA5);
        enable0 = 1'b1;
        #1;
        tests_run++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state0: tx=%b busy=%b state=%0d, required tx=1 busy=0 state=0", tx0, busy0, st0);
        end
        tests_run++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || st1 !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_state1: tx=%b busy=%b state=%0d, required tx=1 busy=0 state=0", tx1, busy1, st1);
        end
        tests_run++;
        if (bus0.fifo_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wins_pop: fifo_rd=%b, required 0", bus0.fifo_rd);
        end
        enable0 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus0.fifo_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_gates_pop: fifo_rd=%b, required 0", bus0.fifo_rd);
        end
    endtask

    task automatic test_single_frame;
        int n, mism, pops_before, rd_sum, busy_sum;
        pops_before = head0;
        enable0 = 1'b1;
        #1;
        tests_run++;
        if (bus0.fifo_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_pop_strobe: fifo_rd=%b, required 1", bus0.fifo_rd);
        end
        record(0, 0, 41);
        build_exp(0, 8'hA5, 1'b0, 1, n);
        tx_exp[n] = 1'b1;
        mism = 0; rd_sum = 0; busy_sum = 0;
        for (int i = 0; i <= n; i++) begin
            if (tx_rec[i] !== tx_exp[i]) mism++;
            if (rd_rec[i] === 1'b1) rd_sum++;
            if (i < n && busy_rec[i] === 1'b1) busy_sum++;
        end
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL single_tx_wave: %0d of %0d cycles differ, required 0", mism, n + 1);
        end
        tests_run++;
        if (busy_sum != 40 || busy_rec[40] !== 1'b0 || st0 !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_busy: busy cycles=%0d end busy=%b state=%0d, required 40/0/0", busy_sum, busy_rec[40], st0);
        end
        tests_run++;
        if ((head0 - pops_before) != 1 || rd_sum != 0) begin
            tests_failed++;
            $display("FAIL single_pop_count: pops=%0d extra strobes=%0d, required 1/0", head0 - pops_before, rd_sum);
        end
    endtask

    task automatic test_back_to_back;
        int n, mism, pops_before, rd_sum, busy_sum;
        pops_before = head0;
        push0(8'h00);
        push0(8'hFF);
        record(0, 0, 81);
        build_exp(0, 8'h00, 1'b0, 1, n);
        build_exp(n, 8'hFF, 1'b0, 1, n);
        tx_exp[n] = 1'b1;
        mism = 0; rd_sum = 0; busy_sum = 0;
        for (int i = 0; i <= n; i++) begin
            if (tx_rec[i] !== tx_exp[i]) mism++;
            if (rd_rec[i] === 1'b1) rd_sum++;
            if (i < n && busy_rec[i] === 1'b1) busy_sum++;
        end
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL b2b_tx_wave: %0d of %0d cycles differ, required 0", mism, n + 1);
        end
        tests_run++;
        if (rd_rec[39] !== 1'b1 || rd_sum != 1 || tx_rec[40] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_pop: rd@39=%b strobes=%0d tx@40=%b, required 1/1/0", rd_rec[39], rd_sum, tx_rec[40]);
        end
        tests_run++;
        if (busy_sum != 80 || busy_rec[80] !== 1'b0 || (head0 - pops_before) != 2) begin
            tests_failed++;
            $display("FAIL b2b_busy_pops: busy=%0d end busy=%b pops=%0d, required 80/0/2", busy_sum, busy_rec[80], head0 - pops_before);
        end
    endtask

    task automatic test_parity;
        int n, mism, pops_before, stop_ones;
        pops_before = head1;
        enable1 = 1'b1;
        push1(8'h07);
        push1(8'h03);
        record(1, 0, 97);
        enable1 = 1'b0;
        build_exp(0, 8'h07, 1'b1, 2, n);
        build_exp(n, 8'h03, 1'b1, 2, n);
        tx_exp[n] = 1'b1;
        mism = 0; stop_ones = 0;
        for (int i = 0; i <= n; i++) if (tx_rec[i] !== tx_exp[i]) mism++;
        for (int i = 40; i < 48; i++) if (tx_rec[i] === 1'b1) stop_ones++;
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL parity_tx_wave: %0d of %0d cycles differ, required 0", mism, n + 1);
        end
        tests_run++;
        if (tx_rec[36] !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_bit_07: got %b, required 1", tx_rec[36]);
        end
        tests_run++;
        if (tx_rec[84] !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_bit_03: got %b, required 0", tx_rec[84]);
        end
        tests_run++;
        if (stop_ones != 8 || rd_rec[47] !== 1'b1 || busy_rec[96] !== 1'b0 || (head1 - pops_before) != 2) begin
            tests_failed++;
            $display("FAIL parity_frame_len: stop ones=%0d rd@47=%b end busy=%b pops=%0d, required 8/1/0/2",
                     stop_ones, rd_rec[47], busy_rec[96], head1 - pops_before);
        end
    endtask

    task automatic test_empty_gating;
        int n, mism, rd_sum, pops_before;
        record(0, 0, 100);
        mism = 0; rd_sum = 0;
        for (int i = 0; i < 100; i++) begin
            if (tx_rec[i] !== 1'b1) mism++;
            if (rd_rec[i] !== 1'b0) rd_sum++;
        end
        tests_run++;
        if (mism != 0 || rd_sum != 0) begin
            tests_failed++;
            $display("FAIL empty_idle: tx low cycles=%0d strobes=%0d, required 0/0", mism, rd_sum);
        end
        pops_before = head0;
        push0(8'h3C);
        record(0, 0, 10);
        enable0 = 1'b0;
        push0(8'h5A);
        record(0, 10, 50);
        build_exp(0, 8'h3C, 1'b0, 1, n);
        for (int i = n; i < 60; i++) tx_exp[i] = 1'b1;
        mism = 0; rd_sum = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_rec[i] !== tx_exp[i]) mism++;
            if (rd_rec[i] === 1'b1) rd_sum++;
        end
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL enable_drop_wave: %0d of 60 cycles differ, required 0", mism);
        end
        tests_run++;
        if (rd_sum != 0 || (head0 - pops_before) != 1 || busy_rec[39] !== 1'b1 || busy_rec[40] !== 1'b0) begin
            tests_failed++;
            $display("FAIL enable_drop_nopop: strobes=%0d pops=%0d busy@39=%b busy@40=%b, required 0/1/1/0",
                     rd_sum, head0 - pops_before, busy_rec[39], busy_rec[40]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n, mism, pops_before;
        pops_before = head0;
        enable0 = 1'b1;
        record(0, 0, 17);
        rst = 1'b1;
        push0(8'hC3);
        #1;
        tests_run++;
        if (bus0.fifo_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_pop: fifo_rd=%b, required 0", bus0.fifo_rd);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 3'd0) begin
            tests_failed++;
            $display("FAIL midrst_abandon: tx=%b busy=%b state=%0d, required 1/0/0", tx0, busy0, st0);
        end
        build_exp(0, 8'h5A, 1'b0, 1, n);
        mism = 0;
        for (int i = 0; i < 17; i++) if (tx_rec[i] !== tx_exp[i]) mism++;
        tests_run++;
        if (mism != 0) begin
            tests_failed++;
            $display("FAIL midrst_partial_wave: %0d of 17 cycles differ, required 0", mism);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus0.fifo_rd !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_fresh_pop: fifo_rd=%b, required 1", bus0.fifo_rd);
        end
        record(0, 0, 41);
        build_exp(0, 8'hC3, 1'b0, 1, n);
        tx_exp[n] = 1'b1;
        mism = 0;
        for (int i = 0; i <= n; i++) if (tx_rec[i] !== tx_exp[i]) mism++;
        tests_run++;
        if (mism != 0 || (head0 - pops_before) != 2 || head0 != tail0) begin
            tests_failed++;
            $display("FAIL midrst_next_frame: wave diffs=%0d pops=%0d left=%0d, required 0/2/0",
                     mism, head0 - pops_before, tail0 - head0);
        end
    endtask

    task automatic test_random;
        int pops_before, budget, nrx;
        logic [7:0] b, got, want;
        pops_before = head0;
        rx_on = 1'b1;
        enable0 = 1'b1;
        for (int i = 0; i < 200; i++) begin
            b = 8'($urandom_range(0, 255));
            push0(b);
            exp_q.push_back(b);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(posedge clk);
            #1;
        end
        budget = 0;
        while (rx_q.size() < 200 && budget < 12000) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        nrx = rx_q.size();
        tests_run++;
        if (nrx != 200) begin
            tests_failed++;
            $display("FAIL random_rx_count: received %0d bytes, required 200", nrx);
        end
        for (int i = 0; i < nrx && exp_q.size() > 0; i++) begin
            got = rx_q.pop_front();
            want = exp_q.pop_front();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random_byte[%0d]: got %02h, required %02h", i, got, want);
            end
        end
        tests_run++;
        if (rx_frame_err != 0 || (head0 - pops_before) != 200) begin
            tests_failed++;
            $display("FAIL random_framing_pops: framing errors=%0d pops=%0d, required 0/200", rx_frame_err, head0 - pops_before);
        end
        tests_run++;
        if (bad_rd0 != 0 || bad_rd1 != 0) begin
            tests_failed++;
            $display("FAIL illegal_pops: dut0=%0d dut1=%0d, required 0/0", bad_rd0, bad_rd1);
        end
        rx_on = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity();
        test_empty_gating();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART serial transmitter that sits directly downstream of the team's byte FIFO.
- Pops one word whenever the FIFO is not empty and serialises it on `tx`: start bit, DATA_WIDTH data bits LSB first, optional even parity, then stop bit(s).
- Back-to-back frames are sent with no idle gap while data remains and `enable` stays high.

Parameters:
- DATA_WIDTH, 8: bits per frame payload; must match the FIFO word width.
- CLK_DIV, 868: clock cycles per bit, for example 100 MHz / 115200 baud. Legal range is 2 to 2**DIV_WIDTH-1.
- DIV_WIDTH, 16: width of the baud counter.
- PARITY_EN, 0: 1 inserts an even parity bit after the data bits.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: permits starting new frames.
- fifo_not_empty, input, 1: FIFO holds at least one word.
- fifo_dout, input, DATA_WIDTH: FIFO head word, valid whenever fifo_not_empty=1 (show-ahead).
- fifo_rd, output, 1: one-cycle pop strobe to the FIFO.
- tx, output, 1: serial line; idles high.
- busy, output, 1: a frame is in progress.

Behaviour:
- **Reset values** (after rst is high at a rising edge): state=IDLE, tx=1, busy=0, baud counter=0, bit counter=0, shift register=0. fifo_rd=0 while rst=1.
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Pop rule:**
  - fifo_rd is combinational. It is 1 when (state==IDLE, or state==STOP on its final tick) and enable=1 and fifo_not_empty=1 and rst=0.
  - On the edge where fifo_rd=1, fifo_dout is captured into the shift register, and the parity bit (XOR of the data) is captured.
  - Exactly one pop per frame; fifo_rd is never asserted while fifo_not_empty=0.
- **Bit timing:**
  - Each bit holds tx for exactly CLK_DIV cycles.
  - The baud counter runs 0..CLK_DIV-1; "tick" means counter==CLK_DIV-1. It resets to 0 on the tick and on entering START.
- **tx is registered.** tx goes to 0 in the first cycle after the pop edge.
- **IDLE:** tx=1, busy=0. On a pop, go to START.
- **START:** tx=0. On tick, go to DATA with bit index 0.
- **DATA:**
  - tx = shift[0].
  - On each tick, shift right and increment the index.
  - After bit DATA_WIDTH-1, go to PARITY if PARITY_EN=1, else STOP.
- **PARITY:** tx = even parity bit, so the total count of 1s across data plus parity is even. On tick, go to STOP.
- **STOP:**
  - tx=1 for STOP_BITS×CLK_DIV cycles.
  - On the final tick: if a pop occurs, go to START (no gap between frames); otherwise go to IDLE.
- **busy** is 1 in START, DATA, PARITY and STOP.
- **Frame length:** (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)×CLK_DIV cycles.
- **enable deasserted mid-frame:** the current frame completes unchanged, and no further pop occurs.
- **FIFO empties mid-frame:** no effect on the current frame; return to IDLE after the stop bit(s).
- **rst asserted mid-frame:**
  - The frame is abandoned. tx=1 from the next edge and state=IDLE.
  - The popped word is lost (not re-queued).
- **rst and pop conditions high in the same cycle:** rst wins; fifo_rd=0.
- **Counter widths:** the baud counter is DIV_WIDTH bits. The bit counter is clog2(DATA_WIDTH+1) bits with no wrap beyond DATA_WIDTH.

Test Plan:
1. **Single frame.** CLK_DIV=4, PARITY_EN=0, STOP_BITS=1; FIFO holds 0xA5; enable=1.
   - Required: fifo_rd high for exactly 1 cycle.
   - Required: tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 for 4 cycles.
   - Required: busy high for 40 cycles, then IDLE.
2. **Back-to-back.** FIFO holds 0x00, 0xFF.
   - Required: the second pop coincides with the last cycle of the first stop bit, and the second start bit begins the very next cycle.
   - Required: total busy = 80 contiguous cycles; exactly 2 pops.
3. **Parity.** PARITY_EN=1, STOP_BITS=2.
   - Send 0x07: parity bit = 1. Send 0x03: parity bit = 0.
   - Required: each frame is 12×CLK_DIV cycles, and tx=1 for 8 cycles at the end.
4. **Empty and enable gating.**
   - With fifo_not_empty=0: tx stays 1 and fifo_rd stays 0 for 100 cycles.
   - enable dropped during DATA: the frame completes, and no pop follows although the FIFO is non-empty.
5. **Reset mid-frame.** Assert rst for 1 cycle during data bit 3.
   - Required: tx=1, busy=0 next cycle.
   - Required: the next frame starts from a fresh pop with a correct start bit and full-length bits.
6. **Randomised.** 200 random bytes through the FIFO plus a UART receiver model.
   - Required: all bytes received in order with no framing errors.
   - Required: pop count equals frames sent.
